// File: rtl/bus_sync_pkg.sv
// Shared constants and helpers for the destination-side CDC bus synchroniser
// and its qualifier sync chain.
package bus_sync_pkg;

  localparam int SYNC_MODE_LEVEL  = 0;
  localparam int SYNC_MODE_TOGGLE = 1;

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

  localparam int OVR_CNT_W = 8;

  // Per-cycle handshake decode for the holding register.
  typedef struct packed {
    logic capture;
    logic accept;
    logic overrun;
  } hs_event_t;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser; also used on the source side to bring
// Sync_Ack back across the boundary.
module sync_chain
  import bus_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  localparam int STAGES = (NUM_STAGES < NUM_STAGES_MIN) ? NUM_STAGES_MIN :
                          (NUM_STAGES > NUM_STAGES_MAX) ? NUM_STAGES_MAX : NUM_STAGES;

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // NOTE: flops take <= so every stage samples the pre-edge value of the one before it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stage_q <= '0;
    else      stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/bus_sync_hs.sv
// Destination-domain bus synchroniser with valid/ready holding register,
// overrun pulse and acceptance-toggle ack. Optional OVERRUN_CNT_EN adds Overrun_Cnt.
module bus_sync_hs
  import bus_sync_pkg::*;
#(
  parameter int Width       = 8,
  parameter int NUM_STAGES  = 2,
  parameter int TOGGLE_MODE = SYNC_MODE_LEVEL
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] P_Data_in,
  input  logic             bus_enable,
  input  logic             Sync_Ready,
  output logic [Width-1:0] Sync_Data,
  output logic             Sync_Valid,
  output logic             enable_pulse_d,
  output logic             Sync_Ack,
`ifdef OVERRUN_CNT_EN
  output logic [OVR_CNT_W-1:0] Overrun_Cnt,
`endif
  output logic             Overrun
);

  logic sync_out;

  sync_chain #(.NUM_STAGES(NUM_STAGES)) u_sync_chain (
    .CLK (CLK),
    .RST (RST),
    .d   (bus_enable),
    .q   (sync_out)
  );

  logic             edge_q,  edge_d;
  logic [Width-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic             ack_q,   ack_d;
  logic             ovr_q,   ovr_d;
  hs_event_t        ev;

  // NOTE: every output of this block is assigned on every path, so no latches form.
  always_comb begin
    ev.capture = (TOGGLE_MODE == SYNC_MODE_TOGGLE) ? (sync_out ^ edge_q)
                                                   : (sync_out & ~edge_q);
    ev.accept  = valid_q & Sync_Ready;
    ev.overrun = ev.capture & valid_q & ~Sync_Ready;

    edge_d  = sync_out;
    data_d  = ev.capture ? P_Data_in : data_q;
    valid_d = ev.capture | (valid_q & ~ev.accept);
    pulse_d = ev.capture;
    ack_d   = ack_q ^ ev.accept;
    ovr_d   = ev.overrun;
  end

  // NOTE: the data holding register is reset too, so Sync_Data is 0 before the first word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Sync_Data      = data_q;
  assign Sync_Valid     = valid_q;
  assign enable_pulse_d = pulse_q;
  assign Sync_Ack       = ack_q;
  assign Overrun        = ovr_q;

`ifdef OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] cnt_q, cnt_d;

  // Counts in step with the Overrun pulse and sticks at all-ones.
  always_comb begin
    cnt_d = ev.overrun ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign Overrun_Cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bus_sync_hs.sv
// Bench for bus_sync_hs: a level-mode (2 stages) and a toggle-mode (3 stages)
// instance, checked every cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_bus_sync_hs;

  localparam int W    = 8;
  localparam int NS_L = 2;
  localparam int NS_T = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]   en, rdy;
  logic [W-1:0] din  [2];
  logic [W-1:0] dout [2];
  logic [1:0]   valid, pulse, ack, ovr;
`ifdef OVERRUN_CNT_EN
  logic [7:0]   cnt [2];
`endif

  int checks = 0;
  int errors = 0;
  int n_pulse_l = 0;

  always #5 clk = ~clk;

  bus_sync_hs #(.Width(W), .NUM_STAGES(NS_L), .TOGGLE_MODE(0)) u_lvl (
    .CLK(clk), .RST(rst_n), .P_Data_in(din[0]), .bus_enable(en[0]),
    .Sync_Ready(rdy[0]), .Sync_Data(dout[0]), .Sync_Valid(valid[0]),
    .enable_pulse_d(pulse[0]), .Sync_Ack(ack[0]),
`ifdef OVERRUN_CNT_EN
    .Overrun_Cnt(cnt[0]),
`endif
    .Overrun(ovr[0])
  );

  bus_sync_hs #(.Width(W), .NUM_STAGES(NS_T), .TOGGLE_MODE(1)) u_tgl (
    .CLK(clk), .RST(rst_n), .P_Data_in(din[1]), .bus_enable(en[1]),
    .Sync_Ready(rdy[1]), .Sync_Data(dout[1]), .Sync_Valid(valid[1]),
    .enable_pulse_d(pulse[1]), .Sync_Ack(ack[1]),
`ifdef OVERRUN_CNT_EN
    .Overrun_Cnt(cnt[1]),
`endif
    .Overrun(ovr[1])
  );

  // Reference model: m_hist[i][k] is bus_enable as sampled k+1 edges ago
  // (zeros before reset release). A capture at this edge depends on the
  // qualifier as sampled NUM_STAGES and NUM_STAGES+1 edges ago.
  logic [15:0]  m_hist [2];
  logic [W-1:0] m_data [2];
  logic [1:0]   m_valid, m_pulse, m_ack, m_ovr;
  int           m_cnt [2];
  logic [1:0]   m_cap, m_acc;

  function automatic logic model_capture(input logic [15:0] h, input int ns, input logic tgl);
    logic seen_now, seen_before;
    seen_now    = h[ns-1];
    seen_before = h[ns];
    return tgl ? (seen_now != seen_before) : (seen_now && !seen_before);
  endfunction

  always_comb begin
    m_cap = '0;
    m_acc = '0;
    for (int i = 0; i < 2; i++) begin
      m_cap[i] = model_capture(m_hist[i], (i == 0) ? NS_L : NS_T, (i == 1));
      m_acc[i] = m_valid[i] && rdy[i];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m_hist[j] <= '0;
        m_data[j] <= '0;
        m_cnt[j]  <= 0;
      end
      m_valid <= '0;
      m_pulse <= '0;
      m_ack   <= '0;
      m_ovr   <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        m_hist[j]  <= {m_hist[j][14:0], en[j]};
        m_pulse[j] <= m_cap[j];
        m_ovr[j]   <= m_cap[j] && m_valid[j] && !rdy[j];
        if (m_cap[j]) m_data[j] <= din[j];
        if (m_acc[j]) m_ack[j]  <= !m_ack[j];
        m_valid[j] <= m_cap[j] ? 1'b1 : (m_acc[j] ? 1'b0 : m_valid[j]);
        if (m_cap[j] && m_valid[j] && !rdy[j] && m_cnt[j] < 255) m_cnt[j] <= m_cnt[j] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d data", i),  64'(dout[i]),  64'(m_data[i]));
      check($sformatf("u%0d valid", i), 64'(valid[i]), 64'(m_valid[i]));
      check($sformatf("u%0d pulse", i), 64'(pulse[i]), 64'(m_pulse[i]));
      check($sformatf("u%0d ack", i),   64'(ack[i]),   64'(m_ack[i]));
      check($sformatf("u%0d ovr", i),   64'(ovr[i]),   64'(m_ovr[i]));
`ifdef OVERRUN_CNT_EN
      check($sformatf("u%0d cnt", i),   64'(cnt[i]),   64'(m_cnt[i]));
`endif
    end
  endtask

  // One destination cycle: let the edge happen, then compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (pulse[0]) n_pulse_l++;
    compare_all();
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = '0;
    rdy    = '0;
    din[0] = '0;
    din[1] = '0;

    // Reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle valid", 64'(valid), 64'(0));
    check("idle data0", 64'(dout[0]), 64'(0));
    check("idle ack",   64'(ack), 64'(0));

    // Basic level-mode capture with consumer ready
    din[0] = 8'hA5; rdy[0] = 1'b1; en[0] = 1'b1;
    repeat (2) tick();
    check("basic early pulse", 64'(pulse[0]), 64'(0));
    tick();
    check("basic data",  64'(dout[0]),  64'(8'hA5));
    check("basic pulse", 64'(pulse[0]), 64'(1));
    check("basic valid", 64'(valid[0]), 64'(1));
    tick();
    check("basic drained", 64'(valid[0]), 64'(0));
    check("basic ack",     64'(ack[0]),   64'(1));
    check("basic pulse1",  64'(pulse[0]), 64'(0));
    en[0] = 1'b0;
    repeat (4) tick();

    // Stall: two captures with no consumer -> latest wins, one overrun
    rdy[0] = 1'b0; din[0] = 8'h11; en[0] = 1'b1;
    repeat (3) tick();
    check("stall first data", 64'(dout[0]), 64'(8'h11));
    check("stall first ovr",  64'(ovr[0]),  64'(0));
    en[0] = 1'b0;
    repeat (3) tick();
    din[0] = 8'h22; en[0] = 1'b1;
    repeat (3) tick();
    check("stall data",  64'(dout[0]),  64'(8'h22));
    check("stall valid", 64'(valid[0]), 64'(1));
    check("stall ovr",   64'(ovr[0]),   64'(1));
`ifdef OVERRUN_CNT_EN
    check("stall cnt",   64'(cnt[0]),   64'(1));
`endif
    tick();
    check("stall ovr once", 64'(ovr[0]), 64'(0));
    en[0] = 1'b0;

    // Simultaneous accept and capture
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    repeat (2) tick();
    din[0] = 8'h33; en[0] = 1'b1;
    repeat (3) tick();
    check("hold data33", 64'(dout[0]), 64'(8'h33));
    en[0] = 1'b0;
    repeat (3) tick();
    din[0] = 8'h44; en[0] = 1'b1;
    repeat (2) tick();
    rdy[0] = 1'b1;
    tick();
    check("simul data",  64'(dout[0]),  64'(8'h44));
    check("simul valid", 64'(valid[0]), 64'(1));
    check("simul ack",   64'(ack[0]),   64'(1));
    check("simul ovr",   64'(ovr[0]),   64'(0));
    en[0] = 1'b0;
    repeat (4) tick();

    // Toggle mode, 3 stages: four toggles five cycles apart
    rdy[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din[1] = W'(k);
      en[1]  = ~en[1];
      repeat (3) tick();
      check($sformatf("toggle%0d early", k), 64'(pulse[1]), 64'(0));
      tick();
      check($sformatf("toggle%0d data", k),  64'(dout[1]),  64'(k));
      check($sformatf("toggle%0d pulse", k), 64'(pulse[1]), 64'(1));
      tick();
    end

    // Reset while a level rise is in flight, release with the level held high
    din[0] = 8'h55; en[0] = 1'b1;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("midrst valid", 64'(valid[0]), 64'(0));
    check("midrst data",  64'(dout[0]),  64'(0));
    rst_n = 1'b1;
    n_pulse_l = 0;
    repeat (2) tick();
    check("post rst early", 64'(pulse[0]), 64'(0));
    tick();
    check("post rst pulse", 64'(pulse[0]), 64'(1));
    check("post rst data",  64'(dout[0]),  64'(8'h55));
    repeat (10) tick();
    check("post rst one capture", 64'(n_pulse_l), 64'(1));

    // Randomised traffic on both instances
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) en[i] = ~en[i];
        rdy[i] = 1'($urandom_range(0, 1));
        din[i] = W'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sync_hs.md
Name: bus_sync_hs

Overview:
- Destination-domain synchroniser for a multi-bit bus that crosses a clock boundary, qualified by a single control bit from the source domain.
- Parametrised successor to the two-flop data synchroniser:
  - configurable data width and synchroniser depth;
  - level-edge or toggle qualifier mode;
  - valid/ready output holding register with overrun detection;
  - acceptance-toggle ack for return to the source domain.
- Sits at the receive side of every CDC bus crossing (register file, UART, ALU config paths).

Parameters:
- Width, 8, data bus width (1..64).
- NUM_STAGES, 2, synchroniser flop count on the qualifier (2..4).
- TOGGLE_MODE, 0, 0 = capture on rising edge of bus_enable; 1 = capture on any transition of bus_enable.

Ports:
- CLK  input  1  destination clock.
- RST  input  1  asynchronous active-low reset.
- P_Data_in  input  Width  source-domain data; stable while qualifier is in flight.
- bus_enable  input  1  source-domain qualifier (level or toggle per TOGGLE_MODE).
- Sync_Ready  input  1  consumer can accept Sync_Data this cycle.
- Sync_Data  output  Width  captured data, registered.
- Sync_Valid  output  1  Sync_Data holds an unconsumed word.
- enable_pulse_d  output  1  one-cycle registered pulse per capture.
- Sync_Ack  output  1  toggles once per accepted word; for return synchronisation.
- Overrun  output  1  one-cycle pulse: capture occurred while the previous word was still unconsumed.

Behaviour:
- Reset: RST low asynchronously clears all outputs and internal flops to 0, including the sync chain, edge flop and overrun counter.
- Sync chain: bus_enable passes through NUM_STAGES flops. The last stage feeds an edge flop.
- Capture condition, combinational:
  - TOGGLE_MODE=0: sync_out && !edge_flop.
  - TOGGLE_MODE=1: sync_out ^ edge_flop.
- Latency: a qualifier change sampled at edge 1 gives capture at edge NUM_STAGES+1 (default: 3rd edge). At that edge Sync_Data <= P_Data_in, enable_pulse_d <= 1 for exactly one cycle, and Sync_Valid <= 1.
- Without capture, Sync_Data holds its value; it is never cleared except by reset.
- Valid/ready, evaluated at each edge:
  - Capture, and not (Sync_Valid && Sync_Ready) in the prior state: if Sync_Valid was 1, Overrun=1 for one cycle. New data overwrites (latest wins). Sync_Valid stays 1.
  - Capture together with Sync_Valid && Sync_Ready: old word is accepted and new word is loaded. Sync_Valid stays 1, Sync_Ack toggles, no Overrun.
  - No capture, Sync_Valid && Sync_Ready: Sync_Valid <= 0, Sync_Ack toggles.
  - Sync_Ready while Sync_Valid=0: no effect.
- Back-to-back: in TOGGLE_MODE=1, consecutive toggles spaced at least one destination cycle apart each produce a capture. In TOGGLE_MODE=0, the level must return low and be seen low by the chain before the next rise is detected.
- Reset mid-transfer: the in-flight qualifier is discarded. Post-reset, the edge flop matches the chain, so no spurious capture on an already-high level in TOGGLE_MODE=0. A held-high level after reset produces one capture once it has propagated.
- P_Data_in is sampled only on the capture edge. No metastability handling on data; stability is a source-side requirement.

Optional Feature:
- Macro OVERRUN_CNT_EN.
- Defined:
  - adds output Overrun_Cnt, 8 bits, reset 0;
  - increments on each Overrun pulse;
  - saturates at 255;
  - cleared only by reset.
- Undefined: port and counter are absent; the Overrun pulse is unchanged.

Decomposition:
- Shared package bus_sync_pkg:
  - mode constants SYNC_MODE_LEVEL=0 and SYNC_MODE_TOGGLE=1;
  - minimum/maximum NUM_STAGES bounds;
  - overrun counter width (8).
- Sub-module sync_chain: parametrised NUM_STAGES single-bit synchroniser with the same CLK/RST. Reused by the source side to synchronise Sync_Ack back.

Test Plan:
- Reset/idle: RST low for 3 cycles, then high, bus_enable=0 -> all outputs 0 for 10 cycles.
- Basic capture, TOGGLE_MODE=0, NUM_STAGES=2: P_Data_in=8'hA5, bus_enable rises before edge 1, Sync_Ready=1 -> at edge 3 Sync_Data=8'hA5, enable_pulse_d=1 for one cycle, Sync_Valid=1. At edge 4 Sync_Valid=0 and Sync_Ack=1.
- Stall/overrun: Sync_Ready=0; capture 8'h11, then 8'h22 -> Sync_Data=8'h22, Sync_Valid stays 1, Overrun pulses once; with OVERRUN_CNT_EN, Overrun_Cnt=1.
- Simultaneous accept and capture: Sync_Valid=1 holding 8'h33, Sync_Ready=1 on the same edge as capture of 8'h44 -> Sync_Data=8'h44, Sync_Valid=1, Sync_Ack toggles, Overrun=0.
- Toggle mode, NUM_STAGES=3: bus_enable toggles 4 times, 5 cycles apart, data 1..4 -> four captures, each 4 edges after its toggle, Sync_Data sequence 1,2,3,4.
- Reset mid-flight: assert RST one cycle after bus_enable rises -> no capture. Release with bus_enable held high in level mode -> exactly one capture after NUM_STAGES+1 edges, then none.
